// File: rtl/link_pkg.sv
// Shared types and helpers for the serial link PHY.
package link_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/link_rx.sv
// Receive half of the serial link: input synchroniser plus deframing FSM.
module link_rx
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ard_rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 error
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 sync1, sync2, line_q;
  logic                 fall;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par;

  // Two-flop synchroniser plus one history flop for edge detection; idle-high reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= ard_rx;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  // A falling edge needs the line to have been high first, so after a
  // framing error (stop=0) nothing re-arms until the line recovers.
  assign fall = line_q & ~sync2;

  // Deframing FSM: mid-start sample, then one sample per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      par      <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      error    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      error    <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // Line back high at mid-start: a glitch, not a frame.
            state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            sh  <= {sync2, sh[DATA_BITS-1:1]};
            if (idx == IDX_LAST) state <= RX_PARITY;
            else                 idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            par   <= sync2;
            state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            rx_byte <= sh;
            if (sync2 && (par == even_parity(sh))) rx_valid <= 1'b1;
            else                                    error    <= 1'b1;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_link.sv
// Serial PHY top: source mux and TX framer, with the RX deframer as a sub-block.
module serial_link
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_pc,
  input  logic                 bus_mar,
  input  logic                 bus_mdr,
  input  logic [15:0]          pc,
  input  logic [15:0]          mar,
  input  logic [15:0]          mdr,
  input  logic                 tx_start,
  input  logic                 tx_hi,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 ard_tx,
  input  logic                 ard_rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 error
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic [15:0]          sel_word;
  logic [DATA_BITS-1:0] sel_byte;
  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 load;

  // Priority source select: PC over MAR over MDR, nothing selected sends zero.
  always_comb begin
    sel_word = 16'h0000;
    if      (bus_pc)  sel_word = pc;
    else if (bus_mar) sel_word = mar;
    else if (bus_mdr) sel_word = mdr;
    sel_byte = tx_hi ? sel_word[15:8] : sel_word[7:0];
  end

  // A request is taken when idle, or on the final stop cycle for back-to-back frames.
  assign load = tx_start &&
                ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == BIT_LAST));

  // TX framer; ard_tx/tx_busy/tx_done are registered so the line is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      ard_tx   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // Raised one cycle early so it coincides with the last stop cycle.
      tx_done <= (tx_state == TX_STOP) && (tx_cnt == DONE_AT);
      if (load) begin
        tx_sh    <= sel_byte;
        tx_par   <= even_parity(sel_byte);
        tx_cnt   <= '0;
        tx_state <= TX_START;
        ard_tx   <= 1'b0;
        tx_busy  <= 1'b1;
      end else begin
        case (tx_state)
          TX_IDLE: begin
            tx_cnt <= '0;
          end
          TX_START: begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_idx   <= '0;
              tx_state <= TX_DATA;
              ard_tx   <= tx_sh[0];
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
          TX_DATA: begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt <= '0;
              if (tx_idx == IDX_LAST) begin
                tx_state <= TX_PARITY;
                ard_tx   <= tx_par;
              end else begin
                tx_idx <= tx_idx + 3'd1;
                tx_sh  <= tx_sh >> 1;
                ard_tx <= tx_sh[1];
              end
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
          TX_PARITY: begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_state <= TX_STOP;
              ard_tx   <= 1'b1;
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
          TX_STOP: begin
            if (tx_cnt == BIT_LAST) begin
              tx_cnt   <= '0;
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end else begin
              tx_cnt <= tx_cnt + CNT_W'(1);
            end
          end
          default: begin
            tx_state <= TX_IDLE;
            ard_tx   <= 1'b1;
            tx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  link_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ard_rx   (ard_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .error    (error)
  );

endmodule

// File: tb/tb_serial_link.sv
// Scoreboard bench for serial_link: TX line bits and RX events checked against bench-built expectations.
module tb_serial_link;
  import link_pkg::*;

  localparam int CPB = 4;
  localparam int FC  = FRAME_BITS * CPB;

  logic        clk, rst_n;
  logic        bus_pc, bus_mar, bus_mdr;
  logic [15:0] pc, mar, mdr;
  logic        tx_start, tx_hi;
  logic        tx_busy, tx_done, ard_tx, ard_rx;
  logic [7:0]  rx_byte;
  logic        rx_valid, error;

  int n_tests = 0;
  int n_fail  = 0;

  logic       tx_q[$];
  logic [9:0] rx_exp_q[$];
  logic [9:0] rx_seen_q[$];

  serial_link #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
    .pc(pc), .mar(mar), .mdr(mdr), .tx_start(tx_start), .tx_hi(tx_hi),
    .tx_busy(tx_busy), .tx_done(tx_done), .ard_tx(ard_tx), .ard_rx(ard_rx),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RX output event as {rx_valid, error, rx_byte}.
  always @(negedge clk)
    if (rst_n && (rx_valid || error)) rx_seen_q.push_back({rx_valid, error, rx_byte});

  // Expected line bits for one frame: start, data LSB first, even parity, stop.
  task automatic push_tx_frame(input logic [7:0] b);
    logic p;
    p = 1'b0;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(b[i]);
      p = p ^ b[i];
    end
    tx_q.push_back(p);
    tx_q.push_back(1'b1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
  endtask

  // Drive one frame on ard_rx with explicit parity and stop bits, then idle high.
  task automatic send_rx(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      ard_rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    ard_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (ard_tx   !== 1'b1)  begin n_fail++; $display("FAIL reset_ard_tx got=%b exp=1", ard_tx); end
    n_tests++; if (tx_busy  !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    n_tests++; if (tx_done  !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
    n_tests++; if (rx_byte  !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
    n_tests++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_tests++; if (error    !== 1'b0)  begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
    rst_n = 1'b1;
  endtask

  task automatic test_tx_basic();
    logic eb;
    eb = 1'b1;
    pc = 16'hA53C; bus_pc = 1'b1; bus_mar = 1'b0; bus_mdr = 1'b0; tx_hi = 1'b0;
    push_tx_frame(8'h3C);
    pulse_start();
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      if (k % CPB == 0) eb = tx_q.pop_front();
      n_tests++; if (ard_tx !== eb) begin n_fail++; $display("FAIL basic_bit k=%0d got=%b exp=%b", k, ard_tx, eb); end
      n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, tx_busy); end
      n_tests++; if (tx_done !== (k == FC - 1)) begin n_fail++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, tx_done, (k == FC - 1)); end
    end
    @(negedge clk);
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%b exp=0", tx_busy); end
    n_tests++; if (ard_tx  !== 1'b1) begin n_fail++; $display("FAIL basic_idle_line got=%b exp=1", ard_tx); end
  endtask

  task automatic test_tx_priority();
    logic eb;
    int   dones;
    eb = 1'b1; dones = 0;
    pc = 16'hA53C; mar = 16'hFFFF; bus_pc = 1'b1; bus_mar = 1'b1; bus_mdr = 1'b0; tx_hi = 1'b1;
    push_tx_frame(8'hA5);
    pulse_start();
    for (int k = 0; k < FC + 4 * CPB; k++) begin
      @(negedge clk);
      if (k < FC) begin
        if (k % CPB == 0) eb = tx_q.pop_front();
      end else begin
        eb = 1'b1;
      end
      if (tx_done) dones++;
      n_tests++; if (ard_tx !== eb) begin n_fail++; $display("FAIL prio_bit k=%0d got=%b exp=%b", k, ard_tx, eb); end
      n_tests++; if (tx_busy !== (k < FC)) begin n_fail++; $display("FAIL prio_busy k=%0d got=%b exp=%b", k, tx_busy, (k < FC)); end
      // Mid-frame request and source change must both be ignored.
      if (k == 20) begin tx_start = 1'b1; pc = 16'h0000; end
      if (k == 21) tx_start = 1'b0;
    end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL prio_frames got=%0d exp=1", dones); end
  endtask

  task automatic test_back_to_back();
    logic eb;
    eb = 1'b1;
    bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b1; mdr = 16'h4007; tx_hi = 1'b0;
    push_tx_frame(8'h07);
    pulse_start();
    for (int k = 0; k < 2 * FC; k++) begin
      @(negedge clk);
      if (k % CPB == 0) eb = tx_q.pop_front();
      n_tests++; if (ard_tx !== eb) begin n_fail++; $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, ard_tx, eb); end
      n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy k=%0d got=%b exp=1", k, tx_busy); end
      n_tests++; if (tx_done !== (k == FC - 1 || k == 2 * FC - 1)) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b", k, tx_done); end
      if (k == FC - 1) begin
        tx_start = 1'b1; tx_hi = 1'b1;
        push_tx_frame(8'h40);
      end
      if (k == FC) tx_start = 1'b0;
    end
    @(negedge clk);
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
  endtask

  task automatic test_rx_good();
    logic [9:0] ex, got;
    rx_exp_q.push_back({1'b1, 1'b0, 8'h3C});
    send_rx(8'h3C, 1'b0, 1'b1);
    while (rx_exp_q.size() > 0) begin
      ex = rx_exp_q.pop_front();
      n_tests++;
      if (rx_seen_q.size() == 0) begin n_fail++; $display("FAIL rx_good missing exp=%h", ex); end
      else begin
        got = rx_seen_q.pop_front();
        if (got !== ex) begin n_fail++; $display("FAIL rx_good got=%h exp=%h", got, ex); end
      end
    end
    n_tests++; if (rx_seen_q.size() != 0) begin n_fail++; $display("FAIL rx_good extra events got=%0d exp=0", rx_seen_q.size()); end
    rx_seen_q.delete();
  endtask

  task automatic test_rx_errors();
    logic [9:0] ex, got;
    rx_exp_q.push_back({1'b0, 1'b1, 8'h01});
    send_rx(8'h01, 1'b0, 1'b1);  // bad parity
    rx_exp_q.push_back({1'b0, 1'b1, 8'h01});
    send_rx(8'h01, 1'b1, 1'b0);  // good parity, bad stop
    while (rx_exp_q.size() > 0) begin
      ex = rx_exp_q.pop_front();
      n_tests++;
      if (rx_seen_q.size() == 0) begin n_fail++; $display("FAIL rx_err missing exp=%h", ex); end
      else begin
        got = rx_seen_q.pop_front();
        if (got !== ex) begin n_fail++; $display("FAIL rx_err got=%h exp=%h", got, ex); end
      end
    end
    n_tests++; if (rx_seen_q.size() != 0) begin n_fail++; $display("FAIL rx_err extra events got=%0d exp=0", rx_seen_q.size()); end
    rx_seen_q.delete();
  endtask

  task automatic test_rx_glitch();
    logic [9:0] ex, got;
    @(posedge clk); #1 ard_rx = 1'b0;
    @(posedge clk); #1 ard_rx = 1'b1;
    repeat (5 * CPB) @(posedge clk);
    n_tests++; if (rx_seen_q.size() != 0) begin n_fail++; $display("FAIL rx_glitch events got=%0d exp=0", rx_seen_q.size()); end
    rx_seen_q.delete();
    rx_exp_q.push_back({1'b1, 1'b0, 8'h55});
    send_rx(8'h55, 1'b0, 1'b1);
    while (rx_exp_q.size() > 0) begin
      ex = rx_exp_q.pop_front();
      n_tests++;
      if (rx_seen_q.size() == 0) begin n_fail++; $display("FAIL rx_after_glitch missing exp=%h", ex); end
      else begin
        got = rx_seen_q.pop_front();
        if (got !== ex) begin n_fail++; $display("FAIL rx_after_glitch got=%h exp=%h", got, ex); end
      end
    end
    n_tests++; if (rx_seen_q.size() != 0) begin n_fail++; $display("FAIL rx_after_glitch extra got=%0d exp=0", rx_seen_q.size()); end
    rx_seen_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic eb;
    eb = 1'b1;
    bus_pc = 1'b0; bus_mar = 1'b1; bus_mdr = 1'b0; mar = 16'h12C3; tx_hi = 1'b0;
    pulse_start();
    // Run into data bit 3 (fifth line bit), where 0xC3 puts a 0 on the line.
    repeat (18) @(negedge clk);
    n_tests++; if (ard_tx !== 1'b0 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%b/%b exp=0/1", ard_tx, tx_busy); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (ard_tx  !== 1'b1) begin n_fail++; $display("FAIL rst_async_line got=%b exp=1", ard_tx); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", tx_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    push_tx_frame(8'hC3);
    pulse_start();
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      if (k % CPB == 0) eb = tx_q.pop_front();
      n_tests++; if (ard_tx !== eb) begin n_fail++; $display("FAIL rst_frame_bit k=%0d got=%b exp=%b", k, ard_tx, eb); end
      n_tests++; if (tx_done !== (k == FC - 1)) begin n_fail++; $display("FAIL rst_frame_done k=%0d got=%b", k, tx_done); end
    end
    @(negedge clk);
    n_tests++; if (tx_busy !== 1'b0 || ard_tx !== 1'b1) begin n_fail++; $display("FAIL rst_frame_end got=%b/%b exp=0/1", tx_busy, ard_tx); end
  endtask

  initial begin
    rst_n = 1'b0; bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
    pc = 16'h0; mar = 16'h0; mdr = 16'h0; tx_start = 1'b0; tx_hi = 1'b0; ard_rx = 1'b1;
    test_reset();
    test_tx_basic();
    test_tx_priority();
    test_back_to_back();
    test_rx_good();
    test_rx_errors();
    test_rx_glitch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
